// File: rtl/holl_mem_arbiter.sv
// holl_mem_arbiter: two-requester round-robin arbiter for one single-port sync RAM,
// with bounded ownership lock and a registered, tag-steered read return path.
module holl_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int MAX_LOCK   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic                  a_lock,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic                  b_lock,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);
    localparam int CW = $clog2(MAX_LOCK + 1);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;
    logic [CW-1:0]         lock_cnt_q, lock_cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [1:0]            rd_v_q, rd_v_d, rd_b_q, rd_b_d;
    logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic                  force_a, force_b, other_req;

    // rr_q: 0 = A has priority on the next conflict, 1 = B
    always_comb begin
        force_b    = (state_q == OWN_A) && b_req && (lock_cnt_q == CW'(MAX_LOCK));
        force_a    = (state_q == OWN_B) && a_req && (lock_cnt_q == CW'(MAX_LOCK));
        a_gnt      = (state_q == IDLE)  ? a_req && (!b_req || !rr_q) :
                     (state_q == OWN_A) ? a_req && !force_b : force_a;
        b_gnt      = (state_q == IDLE)  ? b_req && (!a_req || rr_q) :
                     (state_q == OWN_B) ? b_req && !force_a : force_b;
        mem_we     = (a_gnt && a_we) || (b_gnt && b_we);
        mem_addr   = a_gnt ? a_addr : b_gnt ? b_addr : addr_q;
        mem_din    = a_gnt ? a_wdata : b_gnt ? b_wdata : din_q;
        addr_d     = mem_addr;
        din_d      = mem_din;
        other_req  = (state_q == OWN_A) ? b_req : (state_q == OWN_B) ? a_req : 1'b0;
        lock_cnt_d = (other_req && lock_cnt_q != CW'(MAX_LOCK)) ? lock_cnt_q + CW'(1) : lock_cnt_q;
        rr_d       = a_gnt ? 1'b1 : b_gnt ? 1'b0 : rr_q;
        state_d    = state_q;
        // a fresh lock (or a release) restarts the ownership budget; a re-lock by the owner does not
        if (a_gnt) begin
            state_d = a_lock ? OWN_A : IDLE;
            if (state_q != OWN_A || !a_lock) lock_cnt_d = '0;
        end
        if (b_gnt) begin
            state_d = b_lock ? OWN_B : IDLE;
            if (state_q != OWN_B || !b_lock) lock_cnt_d = '0;
        end
        rd_v_d    = {rd_v_q[0], (a_gnt && !a_we) || (b_gnt && !b_we)};
        rd_b_d    = {rd_b_q[0], b_gnt};
        a_rdata_d = (rd_v_q[0] && !rd_b_q[0]) ? mem_dout : a_rdata_q;
        b_rdata_d = (rd_v_q[0] && rd_b_q[0]) ? mem_dout : b_rdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_q       <= 1'b0;
            lock_cnt_q <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            rd_v_q     <= '0;
            rd_b_q     <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            lock_cnt_q <= lock_cnt_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            rd_v_q     <= rd_v_d;
            rd_b_q     <= rd_b_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
        end
    end

    assign a_rvalid = rd_v_q[1] && !rd_b_q[1];
    assign b_rvalid = rd_v_q[1] && rd_b_q[1];
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
endmodule

// File: doc/holl_mem_arbiter.md
Name: holl_mem_arbiter

Overview:
- Two-requester arbiter sharing one single-port synchronous RAM (default 32 x 32-bit).
- Requester A is the MMIO slot side; requester B is the datapath/engine side.
- Grants at most one access per cycle, round-robin on conflict.
- Supports a bounded lock for read-modify-write sequences.
- Returns registered read data with a one-cycle valid pulse.

Parameters:
DATA_WIDTH, 32, RAM word width
ADDR_WIDTH, 5, RAM address width
MAX_LOCK, 16, maximum consecutive cycles a locked requester keeps ownership while the other requests

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
a_req  input  1  A requests an access this cycle
a_we  input  1  A access is a write (1) or a read (0)
a_lock  input  1  A asks to retain ownership after this access
a_addr  input  ADDR_WIDTH  A address
a_wdata  input  DATA_WIDTH  A write data
a_gnt  output  1  A access accepted this cycle (combinational)
a_rvalid  output  1  A read data valid, one-cycle pulse
a_rdata  output  DATA_WIDTH  A read data, registered
b_*  same set as a_*, for requester B
mem_we  output  1  RAM write enable
mem_addr  output  ADDR_WIDTH  RAM address
mem_din  output  DATA_WIDTH  RAM write data
mem_dout  input  DATA_WIDTH  RAM read data, valid one cycle after the address is issued

Behaviour:
- Reset state: state=IDLE, rr_ptr=A, lock_cnt=0, read-tracking pipe cleared, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
- An asserted reset mid-operation discards in-flight reads; no rvalid is issued for them.
- Grant is combinational from state, rr_ptr and req. At most one of a_gnt/b_gnt is high in any cycle. gnt is never high without the matching req.
- mem_we/mem_addr/mem_din mux the winner's we/addr/wdata in the grant cycle T. With no grant, mem_we=0 and addr/din hold the last winner's values.
- States:
  - IDLE: only one requester active -> that requester is granted. Both active -> rr_ptr side is granted.
  - After any grant, rr_ptr points to the other requester.
  - A granted access with lock=1 -> go to OWN_A or OWN_B and set lock_cnt=0.
  - OWN_x: only x can be granted. x's granted access with lock=0 -> IDLE.
  - OWN_x: lock_cnt increments on each cycle the other requester has req=1. When lock_cnt reaches MAX_LOCK, forced release: the other requester is granted that cycle, rr_ptr points to x, and the next state is IDLE, or OWN_other if the other requester's lock=1.
  - OWN_x with x req=0 and the other requester idle: remain in OWN_x with no grant.
- Read latency:
  - Granted read at edge T -> mem_dout valid in T+1 -> captured into x_rdata at edge T+2.
  - x_rvalid=1 for exactly the cycle following edge T+2.
  - A 2-stage tag pipe (valid, owner) steers data; back-to-back reads are fully pipelined, one result per cycle, in grant order.
- Writes: no rvalid. The RAM commits at edge T.
- x_rdata holds its last value when x_rvalid=0.
- No forwarding. A read granted the cycle after a write to the same address returns the new data. Same-cycle conflicts cannot occur because only one access is granted per cycle.
- Address wrap: addr is used modulo 2^ADDR_WIDTH; there is no range checking.

Test Plan:
- Reset then idle: all outputs 0. A writes 0xDEADBEEF to addr 3, then reads addr 3 -> a_gnt on both cycles; a_rvalid pulses 2 cycles after the read grant with a_rdata=0xDEADBEEF.
- Contention: A and B both req reads every cycle for 6 cycles -> grants alternate A,B,A,B,A,B; each requester gets 3 rvalid pulses in order with correct data; b_rvalid never carries A's data.
- Lock: B does RMW on addr 7 (read with lock=1, then write with lock=0) while A requests continuously -> A is not granted until B's write is granted; A is granted the next cycle.
- Lock timeout (MAX_LOCK=16): A holds lock=1 with req=1 forever while B requests -> after 16 cycles of B req, B is granted once, then the state returns to round-robin.
- Reset mid-read: assert reset 1 cycle after a_gnt for a read -> no a_rvalid afterwards, a_rdata=0, and the next access works normally.
- Address wrap: B writes 0x1 at addr 31 and 0x2 at addr 0; reads of both return 0x1 and 0x2 respectively.
